i2c_reg_arbiter: RTL and testbench
==================================

Name: i2c_reg_arbiter

Overview:
- Sits between the I2C peripheral byte interface and the shared DVL configuration/status register bank.
- Interprets I2C transactions as register-pointer protocol: first written byte = register pointer, following bytes = data.
- Arbitrates the single-port bank between the I2C host path and one local requester (the DSP/status core); I2C has priority.

Parameters:
- ADDR_W, 8, register pointer width; bank depth = 2**ADDR_W.
- DATA_W, 8, register width; fixed to the I2C byte size.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- i2c_start  in  1  1-cycle pulse; START or repeated START with device-address match
- i2c_rw  in  1  valid with i2c_start; 1 = read, 0 = write
- i2c_stop  in  1  1-cycle pulse on STOP
- rx_byte  in  DATA_W  byte received from host
- rx_valid  in  1  1-cycle pulse; rx_byte valid
- tx_req  in  1  1-cycle pulse; peripheral consumed tx_byte and needs the next byte
- tx_byte  out  DATA_W  byte to shift to host
- tx_valid  out  1  tx_byte holds a valid prefetched byte
- loc_req  in  1  local access request; held with fields stable until loc_gnt
- loc_we  in  1  local write enable
- loc_addr  in  ADDR_W  local register address
- loc_wdata  in  DATA_W  local write data
- loc_gnt  out  1  1-cycle grant; access issued to the bank this cycle
- loc_rdata  out  DATA_W  local read data
- loc_rvalid  out  1  1-cycle pulse, one cycle after a read grant
- rb_en, rb_we  out  1  bank access strobe / write enable
- rb_addr  out  ADDR_W  bank address
- rb_wdata  out  DATA_W  bank write data
- rb_rdata  in  DATA_W  bank read data; valid one cycle after rb_en with rb_we=0

Behaviour:
- Reset: all outputs 0; ptr=0; FSM=IDLE; pending I2C access cleared. Reset mid-transaction aborts the access; no partial bank write.
- I2C FSM states: IDLE, PTR, WDATA, RDATA.
  - i2c_start with rw=0, from any state: go to PTR.
  - i2c_start with rw=1, from any state: go to RDATA and prefetch at ptr.
  - PTR + rx_valid: ptr <= rx_byte[ADDR_W-1:0]; go to WDATA.
  - WDATA + rx_valid: queue a write of rx_byte at ptr; ptr++.
  - RDATA + tx_req: tx_valid <= 0; ptr++; prefetch at the new ptr.
  - i2c_stop: go to IDLE. ptr is retained, so write-pointer / repeated-START / read works.
- Prefetch: the bank read issues the cycle it is granted. tx_byte is loaded from rb_rdata the next cycle and tx_valid is set. Latency from tx_req to tx_valid is at most 3 cycles.
- Arbitration:
  - At most one bank access per cycle.
  - A pending I2C access (single-entry register) always wins.
  - loc_gnt is asserted only in a cycle with no pending I2C access. The I2C byte rate guarantees local progress.
- Local read: loc_rvalid is asserted the cycle after loc_gnt with loc_rdata = rb_rdata, registered.
- ptr wraps from 2**ADDR_W-1 to 0.
- Simultaneous events:
  - rx_valid and i2c_stop together: the byte is processed, then the FSM goes to IDLE.
  - i2c_start and rx_valid together: start wins; the byte is dropped.
  - loc_req and a new I2C access in the same cycle: I2C is granted; loc_gnt=0.
- Ignored: rx_valid in IDLE/RDATA; tx_req outside RDATA. Neither changes any state.
- Write-after-read hazard: a local write to ptr while the prefetch is valid does not refresh tx_byte. This is documented stale-read behaviour.

Optional Feature:
- Macro: I2C_REG_AUTOINC_EN.
- Defined: ptr increments after each WDATA byte and each tx_req (burst access).
- Undefined: ptr holds; repeated data bytes rewrite or reread the same register.

Decomposition:
- Package i2c_reg_pkg:
  - FSM state enum i2c_reg_state_t {IDLE, PTR, WDATA, RDATA}
  - ADDR_W/DATA_W defaults
  - access struct {we, addr, wdata}
- One natural sub-module: i2c_reg_ptr_fsm. It holds the I2C-side FSM, pointer and pending-access register. The top holds the arbiter and the read-return path.

Test Plan:
- Write: start rw=0, rx 0x67, rx 0x66, stop -> one bank write addr 0x67 data 0x66; ptr=0x68 (AUTOINC) or 0x67.
- Pointer-then-read: start rw=0, rx 0x67, repeated start rw=1 with bank[0x67]=0x66 -> tx_valid within 3 cycles, tx_byte=0x66.
- Burst read with wrap: ptr=0xFF, 2 tx_req -> bytes bank[0xFF], bank[0x00], bank[0x01] in order (AUTOINC).
- Contention: loc_req write 0x10=0xAA in the same cycle as an I2C write queue -> I2C granted first; loc_gnt the next cycle; both writes land.
- Local read: loc_req read 0x20 (bank=0x5C) -> loc_gnt, then loc_rvalid next cycle with loc_rdata=0x5C.
- Reset mid-WDATA: assert rst between rx_valid and grant -> no bank write; all outputs 0; FSM IDLE; rx_valid ignored until the next start.

Source files
------------

// File: rtl/i2c_reg_pkg.sv
// Shared types for the I2C register-pointer arbiter.
// Define I2C_REG_AUTOINC_EN to make the pointer advance after every data byte (burst access).
package i2c_reg_pkg;

  localparam int I2C_ADDR_W = 8;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [1:0] {IDLE, PTR, WDATA, RDATA} i2c_reg_state_t;

  typedef struct packed {
    logic                  we;
    logic [I2C_ADDR_W-1:0] addr;
    logic [I2C_DATA_W-1:0] wdata;
  } access_t;

  function automatic logic [I2C_ADDR_W-1:0] ptr_step(input logic [I2C_ADDR_W-1:0] p);
`ifdef I2C_REG_AUTOINC_EN
    return p + I2C_ADDR_W'(1);
`else
    return p;
`endif
  endfunction

endpackage

// File: rtl/i2c_reg_ptr_fsm.sv
// I2C-side protocol tracker: state, register pointer and the single-entry pending bank access.
module i2c_reg_ptr_fsm
  import i2c_reg_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i2c_start,
  input  logic                  i2c_rw,
  input  logic                  i2c_stop,
  input  logic [I2C_DATA_W-1:0] rx_byte,
  input  logic                  rx_valid,
  input  logic                  tx_req,
  output logic                  pend_valid,
  output access_t               pend,
  output logic                  queue,
  output logic                  tx_clr
);

  i2c_reg_state_t        state_reg, state_next;
  logic [I2C_ADDR_W-1:0] ptr_reg, ptr_next;
  logic                  pend_valid_reg;
  access_t               pend_reg, acc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      ptr_reg        <= '0;
      pend_valid_reg <= 1'b0;
      pend_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      // The arbiter always serves a pending access the cycle after it is queued,
      // so the entry never has to survive more than one cycle.
      pend_valid_reg <= queue;
      pend_reg       <= acc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    acc_next   = '0;
    queue      = 1'b0;
    tx_clr     = 1'b0;
    if (i2c_start) begin
      tx_clr = 1'b1;
      if (i2c_rw) begin
        state_next    = RDATA;
        queue         = 1'b1;
        acc_next.addr = ptr_reg;
      end else begin
        state_next = PTR;
      end
    end else begin
      case (state_reg)
        PTR: if (rx_valid) begin
          ptr_next   = rx_byte[I2C_ADDR_W-1:0];
          state_next = WDATA;
        end
        WDATA: if (rx_valid) begin
          queue          = 1'b1;
          acc_next.we    = 1'b1;
          acc_next.addr  = ptr_reg;
          acc_next.wdata = rx_byte;
          ptr_next       = ptr_step(ptr_reg);
        end
        RDATA: if (tx_req) begin
          tx_clr        = 1'b1;
          ptr_next      = ptr_step(ptr_reg);
          queue         = 1'b1;
          acc_next.addr = ptr_next;
        end
        default: ;
      endcase
      // A byte arriving with STOP is still consumed above.
      if (i2c_stop) state_next = IDLE;
    end
  end

  assign pend_valid = pend_valid_reg;
  assign pend       = pend_reg;

endmodule

// File: rtl/i2c_reg_arbiter.sv
// Register-pointer bridge between the I2C byte interface and the shared register bank,
// with I2C-priority arbitration against one local requester. Burst mode: I2C_REG_AUTOINC_EN.
module i2c_reg_arbiter
  import i2c_reg_pkg::*;
#(
  parameter int ADDR_W = I2C_ADDR_W,
  parameter int DATA_W = I2C_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i2c_start,
  input  logic              i2c_rw,
  input  logic              i2c_stop,
  input  logic [DATA_W-1:0] rx_byte,
  input  logic              rx_valid,
  input  logic              tx_req,
  output logic [DATA_W-1:0] tx_byte,
  output logic              tx_valid,
  input  logic              loc_req,
  input  logic              loc_we,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [DATA_W-1:0] loc_wdata,
  output logic              loc_gnt,
  output logic [DATA_W-1:0] loc_rdata,
  output logic              loc_rvalid,
  output logic              rb_en,
  output logic              rb_we,
  output logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_wdata,
  input  logic [DATA_W-1:0] rb_rdata
);

  logic    pend_valid, queue, tx_clr;
  access_t pend;
  logic    rd_i2c_reg, loc_rvalid_reg;
  logic    tx_valid_reg;
  logic [DATA_W-1:0] tx_byte_reg;

  i2c_reg_ptr_fsm u_fsm (
    .clk       (clk),
    .rst       (rst),
    .i2c_start (i2c_start),
    .i2c_rw    (i2c_rw),
    .i2c_stop  (i2c_stop),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .tx_req    (tx_req),
    .pend_valid(pend_valid),
    .pend      (pend),
    .queue     (queue),
    .tx_clr    (tx_clr)
  );

  // The local side also yields to an I2C access being queued this cycle, so it
  // is never granted just ahead of a host byte that arrived alongside it.
  always_comb begin
    loc_gnt  = loc_req & ~pend_valid & ~queue & ~rst;
    rb_en    = pend_valid | loc_gnt;
    rb_we    = 1'b0;
    rb_addr  = '0;
    rb_wdata = '0;
    if (pend_valid) begin
      rb_we    = pend.we;
      rb_addr  = pend.addr;
      rb_wdata = pend.wdata;
    end else if (loc_gnt) begin
      rb_we    = loc_we;
      rb_addr  = loc_addr;
      rb_wdata = loc_we ? loc_wdata : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_i2c_reg     <= 1'b0;
      loc_rvalid_reg <= 1'b0;
      tx_valid_reg   <= 1'b0;
      tx_byte_reg    <= '0;
    end else begin
      rd_i2c_reg     <= pend_valid & ~pend.we;
      loc_rvalid_reg <= loc_gnt & ~loc_we;
      if (tx_clr) begin
        tx_valid_reg <= 1'b0;
      end else if (rd_i2c_reg) begin
        tx_byte_reg  <= rb_rdata;
        tx_valid_reg <= 1'b1;
      end
    end
  end

  assign tx_byte    = tx_byte_reg;
  assign tx_valid   = tx_valid_reg;
  assign loc_rvalid = loc_rvalid_reg;
  assign loc_rdata  = loc_rvalid_reg ? rb_rdata : '0;

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Bench for i2c_reg_arbiter: bank model, vector table, corner sequences and random traffic
// checked against a pointer/array reference model.
module tb_i2c_reg_arbiter;

`ifdef I2C_REG_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i2c_start = 0, i2c_rw = 0, i2c_stop = 0, rx_valid = 0, tx_req = 0;
  logic [7:0] rx_byte = 0;
  logic [7:0] tx_byte;
  logic tx_valid;
  logic loc_req = 0, loc_we = 0;
  logic [7:0] loc_addr = 0, loc_wdata = 0;
  logic loc_gnt, loc_rvalid;
  logic [7:0] loc_rdata;
  logic rb_en, rb_we;
  logic [7:0] rb_addr, rb_wdata;
  logic [7:0] rb_rdata = 0;

  always #5 clk = ~clk;

  i2c_reg_arbiter dut (
    .clk(clk), .rst(rst), .i2c_start(i2c_start), .i2c_rw(i2c_rw), .i2c_stop(i2c_stop),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .tx_req(tx_req), .tx_byte(tx_byte),
    .tx_valid(tx_valid), .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr),
    .loc_wdata(loc_wdata), .loc_gnt(loc_gnt), .loc_rdata(loc_rdata), .loc_rvalid(loc_rvalid),
    .rb_en(rb_en), .rb_we(rb_we), .rb_addr(rb_addr), .rb_wdata(rb_wdata), .rb_rdata(rb_rdata)
  );

  // Single-port bank with one-cycle registered read.
  logic [7:0] mem [256];
  int wr_count = 0;
  logic [7:0] last_wa = 0, last_wd = 0;
  always @(posedge clk) begin
    if (rb_en) begin
      if (rb_we) begin
        mem[rb_addr] <= rb_wdata;
        wr_count     <= wr_count + 1;
        last_wa      <= rb_addr;
        last_wd      <= rb_wdata;
      end else begin
        rb_rdata <= mem[rb_addr];
      end
    end
  end

  // Reference model: expected bank contents and the host-visible pointer.
  logic [7:0] exp_mem [256];
  logic [7:0] mptr = 0;
  int checks = 0, failures = 0;

  typedef struct packed {
    logic [7:0] ptr;
    logic [7:0] data;
    logic [7:0] exp_tx;
  } vec_t;
  vec_t vecs [4];

  function automatic logic [7:0] nxt(input logic [7:0] p);
    return AUTOINC ? p + 8'd1 : p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic i2c_begin(input logic rw);
    i2c_start = 1; i2c_rw = rw;
    step();
    i2c_start = 0; i2c_rw = 0;
  endtask

  task automatic rx(input logic [7:0] b);
    rx_byte = b; rx_valid = 1;
    step();
    rx_valid = 0;
    step();
    step();
  endtask

  task automatic stop_t();
    i2c_stop = 1;
    step();
    i2c_stop = 0;
    step();
  endtask

  task automatic treq();
    tx_req = 1;
    step();
    tx_req = 0;
  endtask

  task automatic wait_tx(input string name);
    int n = 0;
    while (!tx_valid && n < 3) begin
      step();
      n++;
    end
    check({name, "_tx_valid"}, tx_valid, 1);
  endtask

  task automatic loc(input logic we, input logic [7:0] a, input logic [7:0] d,
                     output logic [7:0] rd, output logic rv);
    logic g = 0;
    loc_req = 1; loc_we = we; loc_addr = a; loc_wdata = d;
    for (int i = 0; i < 8; i++) begin
      #1;
      g = loc_gnt;
      step();
      if (g) break;
    end
    loc_req = 0; loc_we = 0;
    rd = loc_rdata;
    rv = loc_rvalid;
    check("loc_gnt_bound", g, 1);
    step();
  endtask

  task automatic read_txn(input int n);
    i2c_begin(1);
    wait_tx("rd");
    check("rd_byte", tx_byte, exp_mem[mptr]);
    for (int k = 1; k < n; k++) begin
      treq();
      mptr = nxt(mptr);
      wait_tx("rd_burst");
      check("rd_burst_byte", tx_byte, exp_mem[mptr]);
    end
    stop_t();
  endtask

  initial begin
    logic [7:0] rd, b, a;
    logic rv;
    int wc, diff, n;

    vecs[0] = '{ptr: 8'h67, data: 8'h66, exp_tx: 8'h66};
    vecs[1] = '{ptr: 8'h00, data: 8'h3C, exp_tx: 8'h3C};
    vecs[2] = '{ptr: 8'hFF, data: 8'hC5, exp_tx: 8'hC5};
    vecs[3] = '{ptr: 8'h80, data: 8'h5A, exp_tx: 8'h5A};

    // Reset state, with a local request held to confirm it is not granted.
    loc_req = 1;
    step();
    #1;
    check("rst_loc_gnt", loc_gnt, 0);
    check("rst_rb_en", rb_en, 0);
    check("rst_rb_we", rb_we, 0);
    check("rst_rb_addr", rb_addr, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_loc_rvalid", loc_rvalid, 0);
    check("rst_loc_rdata", loc_rdata, 0);
    loc_req = 0;
    step();
    rst = 0;
    step();

    // Fill the bank through the local port so model and bank start identical.
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      loc(1, 8'(i), b, rd, rv);
      exp_mem[i] = b;
    end
    check("init_writes", wr_count, 256);

    // Vector table: write, pointer retention, then pointer-then-read.
    foreach (vecs[i]) begin
      wc = wr_count;
      i2c_begin(0); rx(vecs[i].ptr); rx(vecs[i].data); stop_t();
      check("vec_wr_count", wr_count, wc + 1);
      check("vec_wr_addr", last_wa, vecs[i].ptr);
      check("vec_wr_data", last_wd, vecs[i].data);
      exp_mem[vecs[i].ptr] = vecs[i].data;
      mptr = nxt(vecs[i].ptr);
      i2c_begin(1);
      wait_tx("vec_retain");
      check("vec_ptr_retained", tx_byte, exp_mem[mptr]);
      stop_t();
      i2c_begin(0); rx(vecs[i].ptr); i2c_begin(1);
      wait_tx("vec_ptr_rd");
      check("vec_ptr_rd_byte", tx_byte, vecs[i].exp_tx);
      stop_t();
      mptr = vecs[i].ptr;
      $display("vec %0d ptr=0x%02h data=0x%02h tx=0x%02h", i, vecs[i].ptr, vecs[i].data, tx_byte);
    end

    // Burst read across the pointer wrap.
    i2c_begin(0); rx(8'hFF); i2c_begin(1);
    mptr = 8'hFF;
    wait_tx("wrap0");
    check("wrap_byte0", tx_byte, exp_mem[mptr]);
    for (int k = 1; k < 3; k++) begin
      treq();
      check("wrap_tx_valid_drop", tx_valid, 0);
      mptr = nxt(mptr);
      wait_tx("wrap");
      check("wrap_byte", tx_byte, exp_mem[mptr]);
    end
    stop_t();
    $display("wrap burst done last=0x%02h", tx_byte);

    // Contention: local write arrives with the host data byte.
    i2c_begin(0); rx(8'h30);
    rx_byte = 8'h77; rx_valid = 1;
    loc_req = 1; loc_we = 1; loc_addr = 8'h10; loc_wdata = 8'hAA;
    #1;
    check("contend_gnt_queue", loc_gnt, 0);
    step();
    rx_valid = 0;
    #1;
    check("contend_i2c_en", rb_en, 1);
    check("contend_i2c_addr", rb_addr, 8'h30);
    check("contend_gnt_pend", loc_gnt, 0);
    step();
    check("contend_loc_gnt", loc_gnt, 1);
    check("contend_loc_addr", rb_addr, 8'h10);
    check("contend_loc_wdata", rb_wdata, 8'hAA);
    step();
    loc_req = 0; loc_we = 0;
    step();
    check("contend_mem_loc", mem[8'h10], 8'hAA);
    check("contend_mem_i2c", mem[8'h30], 8'h77);
    exp_mem[8'h10] = 8'hAA;
    exp_mem[8'h30] = 8'h77;
    stop_t();
    mptr = nxt(8'h30);
    $display("contention i2c 0x30=0x77 then local 0x10=0xAA");

    // Local read timing.
    loc(1, 8'h20, 8'h5C, rd, rv);
    exp_mem[8'h20] = 8'h5C;
    loc_req = 1; loc_we = 0; loc_addr = 8'h20;
    #1;
    check("locrd_gnt", loc_gnt, 1);
    step();
    loc_req = 0;
    check("locrd_rvalid", loc_rvalid, 1);
    check("locrd_rdata", loc_rdata, 8'h5C);
    step();
    check("locrd_rvalid_pulse", loc_rvalid, 0);
    $display("local read 0x20 -> 0x%02h", rd);

    // Reset between a data byte and its bank grant.
    i2c_begin(0); rx(8'h40);
    wc = wr_count;
    rx_byte = 8'h99; rx_valid = 1;
    step();
    rx_valid = 0;
    rst = 1;
    #1;
    check("midrst_rb_en", rb_en, 0);
    check("midrst_tx_valid", tx_valid, 0);
    step();
    step();
    rst = 0;
    step();
    check("midrst_no_write", wr_count, wc);
    rx(8'h55);
    check("midrst_rx_ignored", wr_count, wc);
    check("midrst_mem", mem[8'h40], exp_mem[8'h40]);
    mptr = 8'h00;
    read_txn(1);
    $display("mid-transaction reset, ptr restarts at 0");

    // Random traffic against the reference model.
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 3))
        0: begin
          a = 8'($urandom);
          n = $urandom_range(1, 4);
          i2c_begin(0); rx(a);
          mptr = a;
          for (int k = 0; k < n; k++) begin
            b = 8'($urandom);
            rx(b);
            exp_mem[mptr] = b;
            mptr = nxt(mptr);
          end
          stop_t();
          $display("rand %0d i2c write ptr=0x%02h bytes=%0d", t, a, n);
        end
        1: begin
          n = $urandom_range(1, 4);
          read_txn(n);
          $display("rand %0d i2c read bytes=%0d", t, n);
        end
        2: begin
          a = 8'($urandom); b = 8'($urandom);
          loc(1, a, b, rd, rv);
          exp_mem[a] = b;
          $display("rand %0d local write 0x%02h=0x%02h", t, a, b);
        end
        default: begin
          a = 8'($urandom);
          loc(0, a, 8'h00, rd, rv);
          check("rand_loc_rvalid", rv, 1);
          check("rand_loc_rdata", rd, exp_mem[a]);
          $display("rand %0d local read 0x%02h -> 0x%02h", t, a, rd);
        end
      endcase
    end

    diff = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== exp_mem[i]) diff++;
    check("bank_compare", diff, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
